writeback: RTL and testbench
============================

# writeback

Write-back stage and architectural register file of the SEQ processor. Consumes `valE`/`valM` from the execute and memory stages and commits them to the fifteen Y86-64 program registers on the clock edge. Provides the combinational `valA`/`valB` read ports used by decode. Holds the processor status state machine, which stops all commits after the first non-AOK instruction, and counts retired instructions.

## Interface
Parameters:
- `NREGS`, 15: number of architectural registers. Register IDs are 0x0–0xE; 0xF is RNONE.
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `instr_valid`  in  1  an instruction completes this cycle
- `stat_in`  in  3  instruction status: AOK=1, HLT=2, ADR=3, INS=4
- `dstE`  in  4  destination for `valE`; 0xF means no write
- `dstM`  in  4  destination for `valM`; 0xF means no write
- `valE`  in  64  ALU result from execute
- `valM`  in  64  load data from memory
- `srcA`  in  4  decode read port A ID
- `srcB`  in  4  decode read port B ID
- `valA`  out  64  register[`srcA`], or 0 when `srcA`=0xF
- `valB`  out  64  register[`srcB`], or 0 when `srcB`=0xF
- `stat_out`  out  3  processor status
- `halted`  out  1  high once the state machine leaves RUN
- `retired`  out  `CNT_W`  count of committed AOK instructions

## Operation
- State machine states:
  - RUN: reset state.
  - HALTED: terminal; only `rst_n` exits it.
- Commit condition: `commit = instr_valid && state==RUN && stat_in==AOK`.
- When `commit` is true, at the rising edge:
  - if `dstE`!=0xF: reg[`dstE`] <= `valE`
  - if `dstM`!=0xF: reg[`dstM`] <= `valM`
  - if `dstE`==`dstM`!=0xF: `valM` wins and `valE` is discarded.
  - `retired` <= `retired`+1, wrapping modulo 2^`CNT_W`.
- Transition to HALTED: `instr_valid && state==RUN && stat_in!=AOK`.
  - `stat_out` <= `stat_in`.
  - No register write occurs.
  - `retired` is not incremented.
- `stat_in` values outside 1–4 are treated as INS: `stat_out`=4, and the state machine halts.
- In HALTED:
  - All writes are suppressed.
  - `stat_out`, `halted` and `retired` are frozen.
  - Read ports remain functional so register state can be inspected.
- `instr_valid`=0: no state change of any kind.
- Read ports are combinational from the register array; an ID of 0xF returns 64'h0.

## Timing
- Write latency: a value committed at edge N is visible on `valA`/`valB` after edge N. Same-cycle behaviour is set by the Configuration section.
- Read latency: 0 cycles, combinational on `srcA`/`srcB`.
- `halted` and `stat_out` update at the same edge as the halting instruction.
- Values while `rst_n` is low and immediately after reset:
  - all registers 0
  - `stat_out`=3'd1 (AOK)
  - `halted`=0
  - `retired`=0
  - state RUN
- Reset asserted mid-cycle clears all state at once, including the register array. A write pending at the next edge is lost.

## Configuration
- `WB_BYPASS_EN` defined:
  - `valA`/`valB` forward same-cycle write data when `commit` is true and the source ID matches a destination.
  - When both `dstE` and `dstM` match the source ID, the `valM` forward has priority.
- `WB_BYPASS_EN` undefined: read ports return only the stored register contents, i.e. the old value during a same-cycle write.

## Test plan
- Reset, then read all IDs 0x0–0xF → every `valA`/`valB` = 0, `stat_out`=1, `halted`=0, `retired`=0.
- Commit `dstE`=0x0, `valE`=0x1234 and `dstM`=0x3, `valM`=0xDEAD in one cycle → next cycle `srcA`=0 gives 0x1234 and `srcB`=3 gives 0xDEAD; `retired`=1.
- Commit `dstE`=`dstM`=0x4, `valE`=0x11, `valM`=0x22 → reg4 = 0x22. Same-cycle read of `srcA`=4 returns 0x22 with `WB_BYPASS_EN`, or the old value 0 without it.
- Commit with `stat_in`=3 (ADR), `dstM`=0x5, `valM`=0xFF → reg5 unchanged, `stat_out`=3, `halted`=1, `retired` unchanged. A subsequent AOK write to reg5 is also ignored.
- Preload `retired` to 2^64−1 via 2^64−1 commits (or force in simulation), then one more commit → `retired`=0.
- Assert `rst_n` low asynchronously between edges while in HALTED → registers cleared, `stat_out`=1, `halted`=0 with no clock edge required.

Source files
------------

// File: rtl/writeback.sv
// ----------------------------------------------------------------------------
// writeback
//   Write-back stage and architectural register file of the SEQ processor.
//   Commits valE/valM into the Y86-64 program registers on the rising clock
//   edge, serves the two combinational decode read ports, holds the processor
//   status state machine (RUN -> HALTED on the first non-AOK instruction) and
//   counts retired instructions.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : valA/valB forward same-cycle commit data on an ID match
//                 (valM forward has priority over valE).
//     undefined : valA/valB return stored register contents only.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   instr_valid  in   an instruction completes this cycle
//   stat_in      in   [2:0] instruction status (AOK=1 HLT=2 ADR=3 INS=4)
//   dstE, dstM   in   [3:0] destination IDs, 0xF = no write
//   valE, valM   in   [63:0] execute result / load data
//   srcA, srcB   in   [3:0] decode read IDs, 0xF reads as zero
//   valA, valB   out  [63:0] read data
//   stat_out     out  [2:0] processor status
//   halted       out  high once the state machine has left RUN
//   retired      out  [CNT_W-1:0] count of committed AOK instructions
// ----------------------------------------------------------------------------
module writeback #(
    parameter int NREGS = 15,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [2:0]       stat_in,
    input  logic [3:0]       dstE,
    input  logic [3:0]       dstM,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [63:0]      valA,
    output logic [63:0]      valB,
    output logic [2:0]       stat_out,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] regs [NREGS];
    logic        commit;
    logic        halt_now;
    logic [2:0]  halt_stat;
    logic        wr_e;
    logic        wr_m;

    assign commit   = instr_valid && (state == RUN) && (stat_in == STAT_AOK);
    assign halt_now = instr_valid && (state == RUN) && (stat_in != STAT_AOK);
    assign wr_e     = commit && (dstE != RNONE) && (int'(dstE) < NREGS);
    assign wr_m     = commit && (dstM != RNONE) && (int'(dstM) < NREGS);

    // Undefined status codes are reported as INS.
    always_comb begin
        halt_stat = STAT_INS;
        if (stat_in == STAT_HLT || stat_in == STAT_ADR || stat_in == STAT_INS)
            halt_stat = stat_in;
    end

    // ---------------- status state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (halt_now)
            state_next = HALTED;
    end

    assign halted = (state == HALTED);

    // ---------------- status and retire counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_out <= STAT_AOK;
            retired  <= '0;
        end else begin
            if (halt_now)
                stat_out <= halt_stat;
            if (commit)
                retired <= retired + CNT_W'(1);
        end
    end

    // ---------------- register array ----------------
    // NOTE: the array sits on the async reset because the architecture
    // requires every program register to read zero while and after reset;
    // this costs a flop-based array rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (wr_e)
                regs[dstE] <= valE;
            // NOTE: with non-blocking assignments the last one in program
            // order wins, so placing the valM write after valE gives valM
            // priority when dstE == dstM.
            if (wr_m)
                regs[dstM] <= valM;
        end
    end

    // ---------------- read ports ----------------
    function automatic logic [63:0] read_port(input logic [3:0] id);
        logic [63:0] data;
        data = '0;
        if (id != RNONE && int'(id) < NREGS)
            data = regs[id];
`ifdef WB_BYPASS_EN
        if (wr_m && dstM == id)
            data = valM;
        else if (wr_e && dstE == id)
            data = valE;
`endif
        return data;
    endfunction

    always_comb begin
        valA = read_port(srcA);
        valB = read_port(srcB);
    end

endmodule

// File: tb/tb_writeback.sv
// ----------------------------------------------------------------------------
// tb_writeback
//   Directed testbench for writeback. Stimulus drives one vector per cycle
//   just after the rising edge and pushes the expected outputs for that cycle
//   into a queue; a monitor pops one entry per falling edge and compares.
//   A second instance with a 3-bit retire counter exercises counter wrap.
// ----------------------------------------------------------------------------
module tb_writeback;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [2:0]  stat_in;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB;
    logic [2:0]  stat_out;
    logic        halted;
    logic [63:0] retired;

    logic [63:0] s_valA, s_valB;
    logic [2:0]  s_stat_out;
    logic        s_halted;
    logic [2:0]  s_retired;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  st;
        logic        h;
        logic [63:0] r;
        logic [2:0]  rs;
    } exp_t;

    exp_t exp_q[$];

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    writeback dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stat_in(stat_in),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .stat_out(stat_out), .halted(halted), .retired(retired)
    );

    writeback #(.CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stat_in(stat_in),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .srcA(srcA), .srcB(srcB), .valA(s_valA), .valB(s_valB),
        .stat_out(s_stat_out), .halted(s_halted), .retired(s_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector just after the rising edge.
    task automatic drive(input logic r, input logic iv, input logic [2:0] st,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input logic [3:0] sa, input logic [3:0] sb);
        @(posedge clk);
        #1;
        rst_n = r; instr_valid = iv; stat_in = st;
        dstE = de; valE = ve; dstM = dm; valM = vm;
        srcA = sa; srcB = sb;
    endtask

    task automatic expect_out(input string name, input logic [63:0] a, input logic [63:0] b,
                              input logic [2:0] st, input logic h, input logic [63:0] r);
        exp_t e;
        e.name = name; e.a = a; e.b = b; e.st = st; e.h = h; e.r = r;
        e.rs = r[2:0];
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, ".valA"},     valA,             e.a);
                check({e.name, ".valB"},     valB,             e.b);
                check({e.name, ".stat_out"}, 64'(stat_out),    64'(e.st));
                check({e.name, ".halted"},   64'(halted),      64'(e.h));
                check({e.name, ".retired"},  retired,          e.r);
                check({e.name, ".retired_w3"}, 64'(s_retired), 64'(e.rs));
            end
        end
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; stat_in = 3'd1;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF;
        #12 rst_n = 1'b1;

        // Reset state on every read ID.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 3'd1, 4'hF, 0, 4'hF, 0, 4'(i), 4'(i + 8));
            expect_out($sformatf("rst_id%0d", i), 0, 0, 3'd1, 0, 0);
        end

        // Dual write: reg0 <= 0x1234 (E), reg3 <= 0xDEAD (M).
        drive(1, 1, 3'd1, 4'h0, 64'h1234, 4'h3, 64'hDEAD, 4'h0, 4'h3);
        expect_out("dual_same", BYP ? 64'h1234 : 0, BYP ? 64'hDEAD : 0, 3'd1, 0, 0);
        drive(1, 0, 3'd1, 4'hF, 0, 4'hF, 0, 4'h0, 4'h3);
        expect_out("dual_after", 64'h1234, 64'hDEAD, 3'd1, 0, 1);

        // Same destination on both ports: valM wins.
        drive(1, 1, 3'd1, 4'h4, 64'h11, 4'h4, 64'h22, 4'h4, 4'hF);
        expect_out("collide_same", BYP ? 64'h22 : 0, 0, 3'd1, 0, 1);
        drive(1, 0, 3'd1, 4'hF, 0, 4'hF, 0, 4'h4, 4'h0);
        expect_out("collide_after", 64'h22, 64'h1234, 3'd1, 0, 2);

        // Commit with no destinations: counts but writes nothing; 0xF reads 0.
        drive(1, 1, 3'd1, 4'hF, 64'h99, 4'hF, 64'h98, 4'hF, 4'h0);
        expect_out("nodst", 0, 64'h1234, 3'd1, 0, 2);

        // instr_valid low: destination fields ignored.
        drive(1, 0, 3'd1, 4'h1, 64'h55, 4'h2, 64'h66, 4'h1, 4'h2);
        expect_out("idle_same", 0, 0, 3'd1, 0, 3);
        drive(1, 0, 3'd1, 4'hF, 0, 4'hF, 0, 4'h1, 4'h2);
        expect_out("idle_after", 0, 0, 3'd1, 0, 3);

        // Five more commits: narrow counter passes 7 and wraps to 0 at 8.
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 3'd1, 4'hF, 0, 4'hF, 0, 4'h4, 4'h3);
            expect_out($sformatf("cnt%0d", k), 64'h22, 64'hDEAD, 3'd1, 0, 64'(3 + k));
        end

        // ADR instruction halts; its write to reg5 is dropped.
        drive(1, 1, 3'd3, 4'hF, 0, 4'h5, 64'hFF, 4'h5, 4'h4);
        expect_out("adr_same", 0, 64'h22, 3'd1, 0, 8);
        drive(1, 1, 3'd1, 4'hF, 0, 4'h5, 64'h77, 4'h5, 4'h4);
        expect_out("halt_aok_same", 0, 64'h22, 3'd3, 1, 8);
        drive(1, 0, 3'd1, 4'hF, 0, 4'hF, 0, 4'h5, 4'h0);
        expect_out("halt_read", 0, 64'h1234, 3'd3, 1, 8);

        // Asynchronous reset between edges while halted.
        drive(0, 0, 3'd1, 4'hF, 0, 4'hF, 0, 4'h4, 4'h0);
        expect_out("async_rst", 0, 0, 3'd1, 0, 0);

        // Release reset; undefined status 6 halts with INS.
        drive(1, 1, 3'd6, 4'h2, 64'h5, 4'hF, 0, 4'h2, 4'h3);
        expect_out("bad_stat_same", 0, 0, 3'd1, 0, 0);
        drive(1, 0, 3'd1, 4'hF, 0, 4'hF, 0, 4'h2, 4'h3);
        expect_out("bad_stat_after", 0, 0, 3'd4, 1, 0);

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 10 && exp_q.size() > 0; n++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
